// File: rtl/band_run_encoder.sv
// Run-length encoder for the 4-bit band code stream: one {band, length} token per run,
// buffered in a show-ahead FIFO. Define BAND_RLE_SPLIT_EN to split over-long runs.
module band_run_encoder #(
   parameter int LEN_W = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [3:0]       band_i,
   input  logic             band_valid_i,
   output logic             band_ready_o,
   input  logic             flush_i,
   output logic [3:0]       tok_band_o,
   output logic [LEN_W-1:0] tok_len_o,
   output logic             tok_valid_o,
   input  logic             tok_ready_i,
   output logic             run_open_o,
   output logic             busy_o
);

   // state  | meaning
   // IDLE   | no run open, cur_band/cur_len cleared
   // RUN    | accumulating cur_band for cur_len samples
   typedef enum logic {S_IDLE, S_RUN} state_t;

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int TW = 4 + LEN_W;
   localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
   localparam logic [LEN_W-1:0] MAX_LEN  = {LEN_W{1'b1}};
   localparam logic [LEN_W-1:0] ONE_LEN  = LEN_W'(1);

   state_t           state_q, state_d;
   logic [3:0]       cur_band_q, cur_band_d;
   logic [LEN_W-1:0] cur_len_q, cur_len_d;

   logic [TW-1:0]    mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [3:0]       tok_band_q, tok_band_d;
   logic [LEN_W-1:0] tok_len_q, tok_len_d;
   logic             tok_valid_q, tok_valid_d;

   logic             fifo_full, accept, push, pop;
   logic [TW-1:0]    push_word, head_word;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         cur_band_q  <= '0;
         cur_len_q   <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         tok_band_q  <= '0;
         tok_len_q   <= '0;
         tok_valid_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         cur_band_q  <= cur_band_d;
         cur_len_q   <= cur_len_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         tok_band_q  <= tok_band_d;
         tok_len_q   <= tok_len_d;
         tok_valid_q <= tok_valid_d;
         if (push) mem_q[wr_ptr_q] <= push_word;
      end
   end

   always_comb begin
      state_d    = state_q;
      cur_band_d = cur_band_q;
      cur_len_d  = cur_len_q;
      push       = 1'b0;
      accept     = band_valid_i && band_ready_o;
      if (flush_i && !fifo_full) begin
         push       = (state_q == S_RUN);
         state_d    = S_IDLE;
         cur_band_d = '0;
         cur_len_d  = '0;
      end else if (accept) begin
         case (state_q)
            S_IDLE: begin
               state_d    = S_RUN;
               cur_band_d = band_i;
               cur_len_d  = ONE_LEN;
            end
            S_RUN: begin
               if (band_i != cur_band_q) begin
                  push       = 1'b1;
                  cur_band_d = band_i;
                  cur_len_d  = ONE_LEN;
               end else if (cur_len_q == MAX_LEN) begin
`ifdef BAND_RLE_SPLIT_EN
                  push      = 1'b1;
                  cur_len_d = ONE_LEN;
`else
                  cur_len_d = cur_len_q;
`endif
               end else begin
                  cur_len_d = cur_len_q + 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // FIFO bookkeeping; the head register is loaded with what will be at rd_ptr after this edge
   always_comb begin
      push_word = {cur_band_q, cur_len_q};
      pop       = tok_valid_q && tok_ready_i;
      wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d   = count_q;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
      head_word = (push && (wr_ptr_q == rd_ptr_d)) ? push_word : mem_q[rd_ptr_d];
      tok_band_d  = head_word[TW-1 -: 4];
      tok_len_d   = head_word[LEN_W-1:0];
      tok_valid_d = (count_d != '0);
   end

   always_comb begin
      fifo_full    = (count_q == FULL_CNT);
      band_ready_o = !fifo_full && !flush_i;
      busy_o       = flush_i && fifo_full && (state_q == S_RUN);
      run_open_o   = (state_q == S_RUN);
      tok_band_o   = tok_band_q;
      tok_len_o    = tok_len_q;
      tok_valid_o  = tok_valid_q;
   end

endmodule

// File: tb/tb_band_run_encoder.sv
// Directed bench for band_run_encoder (LEN_W=4, DEPTH=4); expectations follow BAND_RLE_SPLIT_EN.
module tb_band_run_encoder;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic [3:0] band_i = '0;
   logic       band_valid_i = 1'b0;
   logic       band_ready_o;
   logic       flush_i = 1'b0;
   logic [3:0] tok_band_o;
   logic [3:0] tok_len_o;
   logic       tok_valid_o;
   logic       tok_ready_i = 1'b0;
   logic       run_open_o;
   logic       busy_o;

   int n_cmp = 0;
   int n_fail = 0;
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];

   band_run_encoder #(.LEN_W(4), .DEPTH(4)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .band_i(band_i), .band_valid_i(band_valid_i),
      .band_ready_o(band_ready_o), .flush_i(flush_i), .tok_band_o(tok_band_o),
      .tok_len_o(tok_len_o), .tok_valid_o(tok_valid_o), .tok_ready_i(tok_ready_i),
      .run_open_o(run_open_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic bv; logic [3:0] b; logic tr; logic fl;
      logic tv; logic [3:0] tb; logic [3:0] tl; logic ro; logic br; logic bz;
   } vec_t;
   vec_t vecs[12];

   function automatic vec_t mk(int bv, int b, int tr, int fl, int tv, int tb, int tl,
                               int ro, int br, int bz);
      vec_t v;
      v.bv = 1'(bv); v.b = 4'(b); v.tr = 1'(tr); v.fl = 1'(fl);
      v.tv = 1'(tv); v.tb = 4'(tb); v.tl = 4'(tl);
      v.ro = 1'(ro); v.br = 1'(br); v.bz = 1'(bz);
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Called just after a negedge: records a pop due at the coming posedge, ends at the next negedge.
   task automatic tick();
      #2;
      if (tok_valid_o && tok_ready_i) got_q.push_back({tok_band_o, tok_len_o});
      @(negedge clk_i);
   endtask

   task automatic drain(input int n);
      band_valid_i = 1'b0;
      flush_i = 1'b0;
      tok_ready_i = 1'b1;
      repeat (n) tick();
   endtask

   task automatic feed(input int b);
      band_valid_i = 1'b1;
      band_i = 4'(b);
      tick();
      band_valid_i = 1'b0;
   endtask

   task automatic reset_dut();
      rst_ni = 1'b0;
      band_valid_i = 1'b0; flush_i = 1'b0; tok_ready_i = 1'b0; band_i = '0;
      @(negedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      got_q.delete();
   endtask

   task automatic chk_tokens(input string name);
      chk({name, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk($sformatf("%s_tok%0d", name, i), int'(got_q[i]), int'(exp_q[i]));
   endtask

   initial begin
      int idx;
      logic acc;
      int seq2[6] = '{1, 2, 1, 2, 1, 2};

      vecs[0]  = mk(1, 1, 1, 0,  0, 0, 0,  0, 1, 0);
      vecs[1]  = mk(1, 1, 1, 0,  0, 0, 0,  1, 1, 0);
      vecs[2]  = mk(1, 1, 1, 0,  0, 0, 0,  1, 1, 0);
      vecs[3]  = mk(1, 2, 1, 0,  0, 0, 0,  1, 1, 0);
      vecs[4]  = mk(1, 2, 1, 0,  1, 1, 3,  1, 1, 0);
      vecs[5]  = mk(1, 2, 1, 0,  0, 0, 0,  1, 1, 0);
      vecs[6]  = mk(1, 3, 1, 0,  0, 0, 0,  1, 1, 0);
      vecs[7]  = mk(1, 3, 1, 0,  1, 2, 3,  1, 1, 0);
      vecs[8]  = mk(1, 3, 1, 0,  0, 0, 0,  1, 1, 0);
      vecs[9]  = mk(0, 0, 1, 1,  0, 0, 0,  1, 0, 0);
      vecs[10] = mk(0, 0, 1, 0,  1, 3, 3,  0, 1, 0);
      vecs[11] = mk(0, 0, 1, 0,  0, 0, 0,  0, 1, 0);

      // reset state, including band_ready following flush while in reset
      #2;
      chk("rst_tok_valid", tok_valid_o, 0);
      chk("rst_tok_len", tok_len_o, 0);
      chk("rst_run_open", run_open_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_ready", band_ready_o, 1);
      flush_i = 1'b1;
      #1 chk("rst_ready_flush", band_ready_o, 0);
      reset_dut();

      // basic stream 1,1,1,2,2,2,3,3,3 then flush
      for (int i = 0; i < 12; i++) begin
         band_valid_i = vecs[i].bv; band_i = vecs[i].b;
         tok_ready_i = vecs[i].tr; flush_i = vecs[i].fl;
         #1;
         chk($sformatf("v%0d_tok_valid", i), tok_valid_o, vecs[i].tv);
         if (vecs[i].tv) begin
            chk($sformatf("v%0d_tok_band", i), tok_band_o, vecs[i].tb);
            chk($sformatf("v%0d_tok_len", i), tok_len_o, vecs[i].tl);
         end
         chk($sformatf("v%0d_run_open", i), run_open_o, vecs[i].ro);
         chk($sformatf("v%0d_ready", i), band_ready_o, vecs[i].br);
         chk($sformatf("v%0d_busy", i), busy_o, vecs[i].bz);
         tick();
      end

      // backpressure: FIFO fills, samples stall, drain then resume
      reset_dut();
      for (int k = 0; k < 5; k++) begin
         band_valid_i = 1'b1; band_i = 4'(seq2[k]);
         #1 chk("bp_ready_fill", band_ready_o, 1);
         tick();
      end
      band_i = 4'd2;
      #1;
      chk("bp_ready_full", band_ready_o, 0);
      chk("bp_head", int'({tok_band_o, tok_len_o}), 8'h11);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("bp_ready_stall", band_ready_o, 0);
      end
      tok_ready_i = 1'b1;
      idx = 5;
      for (int c = 0; c < 30 && idx < 6; c++) begin
         band_valid_i = 1'b1; band_i = 4'(seq2[idx]);
         #1 acc = band_ready_o;
         tick();
         if (acc) idx++;
      end
      band_valid_i = 1'b0;
      chk("bp_resumed", idx, 6);
      flush_i = 1'b1;
      tick();
      drain(8);
      exp_q = '{8'h11, 8'h21, 8'h11, 8'h21, 8'h11, 8'h21};
      chk_tokens("bp");

      // long dwell: 20 x band 5 then band 6
      reset_dut();
      tok_ready_i = 1'b1;
      for (int k = 0; k < 20; k++) feed(5);
      chk("long_run_open", run_open_o, 1);
      feed(6);
      flush_i = 1'b1;
      tick();
      drain(6);
`ifdef BAND_RLE_SPLIT_EN
      exp_q = '{8'h5F, 8'h55, 8'h61};
`else
      exp_q = '{8'h5F, 8'h61};
`endif
      chk_tokens("long");

      // flush held off while full with a run open
      reset_dut();
      for (int k = 0; k < 5; k++) feed(seq2[k]);
      band_valid_i = 1'b1; band_i = 4'd2; flush_i = 1'b1;
      #1;
      chk("fl_busy0", busy_o, 1);
      chk("fl_ready0", band_ready_o, 0);
      chk("fl_open0", run_open_o, 1);
      tick();
      chk("fl_busy1", busy_o, 1);
      tick();
      chk("fl_busy2", busy_o, 1);
      chk("fl_ready2", band_ready_o, 0);
      tok_ready_i = 1'b1;
      tick();
      tok_ready_i = 1'b0;
      #1;
      chk("fl_busy_after_pop", busy_o, 0);
      chk("fl_ready_after_pop", band_ready_o, 0);
      chk("fl_open_after_pop", run_open_o, 1);
      tick();
      chk("fl_open_serviced", run_open_o, 0);
      chk("fl_busy_serviced", busy_o, 0);
      drain(8);
      exp_q = '{8'h11, 8'h21, 8'h11, 8'h21, 8'h11};
      chk_tokens("fl");

      // asynchronous reset mid-stream with two tokens queued and a run of 7
      reset_dut();
      feed(3); feed(4);
      for (int k = 0; k < 7; k++) feed(5);
      chk("ar_pre_valid", tok_valid_o, 1);
      chk("ar_pre_open", run_open_o, 1);
      #2 rst_ni = 1'b0;
      #1;
      chk("ar_tok_valid", tok_valid_o, 0);
      chk("ar_tok_len", tok_len_o, 0);
      chk("ar_tok_band", tok_band_o, 0);
      chk("ar_run_open", run_open_o, 0);
      chk("ar_ready", band_ready_o, 1);
      got_q.delete();
      @(negedge clk_i);
      rst_ni = 1'b1;
      tok_ready_i = 1'b1;
      chk("ar_post_valid", tok_valid_o, 0);
      feed(9); feed(9);
      flush_i = 1'b1;
      tick();
      drain(4);
      exp_q = '{8'h92};
      chk_tokens("ar");

      // push and pop together at count DEPTH-1 across pointer wrap
      reset_dut();
      for (int k = 1; k <= 4; k++) feed(k);
      tok_ready_i = 1'b1;
      for (int k = 5; k <= 14; k++) begin
         band_valid_i = 1'b1; band_i = 4'(k);
         #1;
         chk("pp_ready", band_ready_o, 1);
         chk("pp_valid", tok_valid_o, 1);
         tick();
      end
      band_valid_i = 1'b0;
      flush_i = 1'b1;
      tick();
      drain(8);
      exp_q = '{8'h11, 8'h21, 8'h31, 8'h41, 8'h51, 8'h61, 8'h71,
                8'h81, 8'h91, 8'hA1, 8'hB1, 8'hC1, 8'hD1, 8'hE1};
      chk_tokens("pp");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
